// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter slice.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit shift register with sync clear, parallel load and 1-bit shift.
// The bit exposed on out_bit is the next one the serializer will send.
module piso_shreg
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_bit
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    // The first bit leaves straight from din, so a load keeps only the rest.
    always_comb begin
        data_d = data_q;
        if (clr)
            data_d = '0;
        else if (load)
            data_d = shift_once(load_data);
        else if (shift)
            data_d = shift_once(data_q);
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_bit = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, one bit per
// clock on sout with registered frame_start/frame_done strobes.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;

    logic at_last;
    logic accept;
    logic first_bit;
    logic shreg_bit;
    logic shreg_load;
    logic shreg_shift;

    assign at_last    = (cnt_q == LAST_CNT);
    assign load_ready = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & at_last));
    assign accept     = load_valid & load_ready;
    assign first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign cnt_inc    = cnt_q + CNT_W'(1);

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk       (clk),
        .clr       (rst),
        .load      (shreg_load),
        .shift     (shreg_shift),
        .load_data (din),
        .out_bit   (shreg_bit)
    );

    // Acceptance wins in either state, which is what makes frames abut.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sout_d        = sout_q;
        sout_valid_d  = sout_valid_q;
        frame_start_d = frame_start_q;
        frame_done_d  = frame_done_q;
        shreg_load    = 1'b0;
        shreg_shift   = 1'b0;

        if (accept) begin
            state_d       = ST_SHIFT;
            cnt_d         = '0;
            sout_d        = first_bit;
            sout_valid_d  = 1'b1;
            frame_start_d = 1'b1;
            frame_done_d  = 1'b0;
            shreg_load    = 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (at_last) begin
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                        sout_d        = 1'b0;
                        sout_valid_d  = 1'b0;
                        frame_start_d = 1'b0;
                        frame_done_d  = 1'b0;
                    end else begin
                        cnt_d         = cnt_inc;
                        sout_d        = shreg_bit;
                        frame_start_d = 1'b0;
                        frame_done_d  = (cnt_inc == LAST_CNT);
                        shreg_shift   = 1'b1;
                    end
                end
                default: begin
                    sout_d        = 1'b0;
                    sout_valid_d  = 1'b0;
                    frame_start_d = 1'b0;
                    frame_done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share all
// inputs and are checked every cycle against a queue of expected frame bits.
module tb_piso_serializer;

    typedef struct packed {
        logic m;
        logic l;
        logic start;
        logic done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       load_valid;

    logic m_ready, m_sout, m_valid, m_start, m_done;
    logic l_ready, l_sout, l_valid, l_start, l_done;

    exp_t exp_q[$];
    int   checks;
    int   fails;

    logic [1:0] ready_w;
    logic [7:0] obs;

    assign ready_w = {l_ready, m_ready};
    assign obs     = {l_sout, m_sout, l_valid, m_valid, l_start, m_start, l_done, m_done};

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .load_valid  (load_valid),
        .load_ready  (m_ready),
        .sout        (m_sout),
        .sout_valid  (m_valid),
        .frame_start (m_start),
        .frame_done  (m_done)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .load_valid  (load_valid),
        .load_ready  (l_ready),
        .sout        (l_sout),
        .sout_valid  (l_valid),
        .frame_start (l_start),
        .frame_done  (l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_obs(input exp_t e);
        return {e.l, e.m, 2'b11, e.start, e.start, e.done, e.done};
    endfunction

    task automatic push_frame(input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.m     = w[7-i];
            e.l     = w[i];
            e.start = (i == 0);
            e.done  = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_valid = 1'b1;
        din        = 8'hA5;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== 8'h00) begin
                fails++;
                $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 8'h00);
            end
            checks++;
            if (ready_w !== 2'b00) begin
                fails++;
                $display("[TB] FAIL reset_ready: got %b expected %b", ready_w, 2'b00);
            end
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        #1;
        checks++;
        if (ready_w !== 2'b11) begin
            fails++;
            $display("[TB] FAIL ready_after_reset: got %b expected %b", ready_w, 2'b11);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 8'h00) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b", obs, 8'h00);
        end
    endtask

    task automatic test_single_frame(input logic [7:0] w);
        exp_t e;
        checks++;
        if (ready_w !== 2'b11) begin
            fails++;
            $display("[TB] FAIL frame_%h_ready_idle: got %b expected %b", w, ready_w, 2'b11);
        end
        din        = w;
        load_valid = 1'b1;
        push_frame(w);
        @(posedge clk); #1;
        load_valid = 1'b0;
        din        = 8'h00;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== exp_obs(e)) begin
                fails++;
                $display("[TB] FAIL frame_%h_bit%0d: got %b expected %b", w, i, obs, exp_obs(e));
            end
            checks++;
            if (ready_w !== {2{i == 7}}) begin
                fails++;
                $display("[TB] FAIL frame_%h_ready%0d: got %b expected %b", w, i, ready_w, {2{i == 7}});
            end
            @(posedge clk); #1;
        end
        checks++;
        if (obs !== 8'h00 || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL frame_%h_end: got %b/%0d expected %b/0", w, obs, exp_q.size(), 8'h00);
        end
    endtask

    task automatic test_ignore_in_shift();
        exp_t e;
        din        = 8'h5A;
        load_valid = 1'b1;
        push_frame(8'h5A);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== exp_obs(e)) begin
                fails++;
                $display("[TB] FAIL ignore_bit%0d: got %b expected %b", i, obs, exp_obs(e));
            end
            load_valid = (i < 7) && (i % 2 == 0);
            din        = 8'($urandom);
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        checks++;
        if (obs !== 8'h00 || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL ignore_end: got %b/%0d expected %b/0", obs, exp_q.size(), 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [15:0] stream_m;
        logic [15:0] stream_l;
        stream_m = '0;
        stream_l = '0;
        checks++;
        if (ready_w !== 2'b11) begin
            fails++;
            $display("[TB] FAIL b2b_ready_cycle0: got %b expected %b", ready_w, 2'b11);
        end
        din        = 8'hC1;
        load_valid = 1'b1;
        push_frame(8'hC1);
        @(posedge clk); #1;
        din = 8'h3C;
        push_frame(8'h3C);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== exp_obs(e)) begin
                fails++;
                $display("[TB] FAIL b2b_bit%0d: got %b expected %b", i, obs, exp_obs(e));
            end
            checks++;
            if (ready_w !== {2{i % 8 == 7}}) begin
                fails++;
                $display("[TB] FAIL b2b_ready%0d: got %b expected %b", i, ready_w, {2{i % 8 == 7}});
            end
            stream_m = {stream_m[14:0], m_sout};
            stream_l = {stream_l[14:0], l_sout};
            if (i == 8)
                load_valid = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (stream_m !== 16'b11000001_00111100) begin
            fails++;
            $display("[TB] FAIL b2b_stream_msb: got %b expected %b", stream_m, 16'b11000001_00111100);
        end
        checks++;
        if (stream_l !== 16'b10000011_00111100) begin
            fails++;
            $display("[TB] FAIL b2b_stream_lsb: got %b expected %b", stream_l, 16'b10000011_00111100);
        end
        checks++;
        if (obs !== 8'h00 || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL b2b_end: got %b/%0d expected %b/0", obs, exp_q.size(), 8'h00);
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        din        = 8'hFF;
        load_valid = 1'b1;
        push_frame(8'hFF);
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== exp_obs(e)) begin
                fails++;
                $display("[TB] FAIL midrst_bit%0d: got %b expected %b", i, obs, exp_obs(e));
            end
            if (i == 3)
                rst = 1'b1;
            @(posedge clk); #1;
        end
        exp_q.delete();
        checks++;
        if (obs !== 8'h00) begin
            fails++;
            $display("[TB] FAIL midrst_abort: got %b expected %b", obs, 8'h00);
        end
        checks++;
        if (ready_w !== 2'b00) begin
            fails++;
            $display("[TB] FAIL midrst_ready: got %b expected %b", ready_w, 2'b00);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== 8'h00) begin
            fails++;
            $display("[TB] FAIL midrst_no_done: got %b expected %b", obs, 8'h00);
        end
        test_single_frame(8'h81);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b1;
        load_valid = 1'b0;
        din        = 8'h00;

        test_reset();
        test_single_frame(8'hC1);
        test_ignore_in_shift();
        test_back_to_back();
        test_reset_midframe();
        repeat (4) test_single_frame(8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
